// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear control for the millisecond timer datapath: key debounce, FSM, rollover latch.
// Optional lap counter is compiled in with `define LAP_COUNTER_EN; otherwise lap_count is tied to 0.
module stopwatch_ctrl #(
    parameter int DEBOUNCE_MS = 20,
    parameter int LAP_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1khz,
    input  logic             key_start_n,
    input  logic             key_lap_n,
    input  logic             key_clear_n,
    input  logic             timer_wrap,
    output logic             count_en,
    output logic             count_clr,
    output logic             display_hold,
    output logic             overflow,
    output logic [1:0]       state,
    output logic [LAP_W-1:0] lap_count
);

    localparam int CNT_W   = $clog2(DEBOUNCE_MS + 1);
    localparam int K_START = 0;
    localparam int K_LAP   = 1;
    localparam int K_CLEAR = 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_LAP   = 2'b10,
        S_PAUSE = 2'b11
    } state_e;

    logic [2:0]       key_raw;
    logic [2:0]       sync1_q, sync2_q;
    logic [2:0]       deb_q, deb_d;
    logic [2:0]       press;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    state_e state_q, state_d;
    logic   count_en_q, count_en_d;
    logic   count_clr_q, count_clr_d;
    logic   hold_q, hold_d;
    logic   overflow_q, overflow_d;
    logic   clr_act;

    assign key_raw = {key_clear_n, key_lap_n, key_start_n};

    // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                cnt_d[i] = cnt_q[i];
                if (tick_1khz) begin
                    if (cnt_q[i] == CNT_W'(DEBOUNCE_MS - 1)) begin
                        deb_d[i] = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
        // A press is the debounced level falling; releases are not events.
        press = deb_q & ~deb_d;
    end

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        clr_act    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (press[K_CLEAR])      clr_act = 1'b1;
                else if (press[K_START]) state_d = S_RUN;
            end
            S_RUN: begin
                if (timer_wrap) begin
                    state_d    = S_PAUSE;
                    overflow_d = 1'b1;
                end else if (press[K_START]) state_d = S_PAUSE;
                else if (press[K_LAP])       state_d = S_LAP;
            end
            S_LAP: begin
                if (timer_wrap) begin
                    state_d    = S_PAUSE;
                    overflow_d = 1'b1;
                end else if (press[K_START]) state_d = S_PAUSE;
                else if (press[K_LAP])       state_d = S_RUN;
            end
            S_PAUSE: begin
                if (press[K_CLEAR]) begin
                    clr_act    = 1'b1;
                    overflow_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (press[K_START]) state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        // Enable uses the pre-transition state; clear is only legal while stopped, so the two never overlap.
        count_en_d  = tick_1khz & ((state_q == S_RUN) | (state_q == S_LAP));
        count_clr_d = clr_act;
        hold_d      = (state_d == S_LAP);
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '1;
            sync2_q     <= '1;
            deb_q       <= '1;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q     <= S_IDLE;
            count_en_q  <= 1'b0;
            count_clr_q <= 1'b0;
            hold_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= key_raw;
            sync2_q     <= sync1_q;
            deb_q       <= deb_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q     <= state_d;
            count_en_q  <= count_en_d;
            count_clr_q <= count_clr_d;
            hold_q      <= hold_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef LAP_COUNTER_EN
    logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
    logic             lap_inc;

    assign lap_inc = (state_q == S_RUN) && (state_d == S_LAP);

    always_comb begin
        lap_cnt_d = lap_cnt_q;
        if (clr_act)                             lap_cnt_d = '0;
        else if (lap_inc && (lap_cnt_q != '1))   lap_cnt_d = lap_cnt_q + LAP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lap_cnt_q <= '0;
        else        lap_cnt_q <= lap_cnt_d;
    end

    assign lap_count = lap_cnt_q;
`else
    assign lap_count = '0;
`endif

    assign count_en     = count_en_q;
    assign count_clr    = count_clr_q;
    assign display_hold = hold_q;
    assign overflow     = overflow_q;
    assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: event-level reference model compared every cycle plus directed literals.
module tb_stopwatch_ctrl;

    localparam int DB     = 2;
    localparam int LAP_W  = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             tick_1khz = 1'b0;
    logic             key_start_n = 1'b1;
    logic             key_lap_n = 1'b1;
    logic             key_clear_n = 1'b1;
    logic             timer_wrap = 1'b0;
    logic             count_en, count_clr, display_hold, overflow;
    logic [1:0]       state;
    logic [LAP_W-1:0] lap_count;

    int n_checks = 0;
    int n_errors = 0;

    stopwatch_ctrl #(.DEBOUNCE_MS(DB), .LAP_W(LAP_W)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1khz(tick_1khz),
        .key_start_n(key_start_n), .key_lap_n(key_lap_n), .key_clear_n(key_clear_n),
        .timer_wrap(timer_wrap), .count_en(count_en), .count_clr(count_clr),
        .display_hold(display_hold), .overflow(overflow), .state(state), .lap_count(lap_count)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (9) @(posedge clk);
            #1 tick_1khz = 1'b1;
            @(posedge clk);
            #1 tick_1khz = 1'b0;
        end
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: key -> stable-level tracker -> event list -> transition table.
    int m_s1[3], m_s2[3], m_lvl[3], m_diff_ticks[3];
    bit m_ev[3];
    int m_mode, m_ovf, m_laps, e_en, e_clr, e_hold;

    // Returns next mode for an event (0 clear, 1 start, 2 lap), or -1 when the event is not legal.
    function automatic int next_mode(input int mode, input int ev);
        case (mode)
            M_IDLE:  return (ev == 0) ? M_IDLE : (ev == 1) ? M_RUN : -1;
            M_RUN:   return (ev == 1) ? M_PAUSE : (ev == 2) ? M_LAP : -1;
            M_LAP:   return (ev == 2) ? M_RUN : (ev == 1) ? M_PAUSE : -1;
            default: return (ev == 1) ? M_RUN : (ev == 0) ? M_IDLE : -1;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_s1[k] = 1; m_s2[k] = 1; m_lvl[k] = 1; m_diff_ticks[k] = 0;
            end
            m_mode = M_IDLE; m_ovf = 0; m_laps = 0; e_en = 0; e_clr = 0; e_hold = 0;
        end else begin
            int raw[3];
            int nm;
            raw[0] = int'(key_start_n); raw[1] = int'(key_lap_n); raw[2] = int'(key_clear_n);
            for (int k = 0; k < 3; k++) begin
                m_ev[k] = 1'b0;
                if (m_s2[k] == m_lvl[k]) m_diff_ticks[k] = 0;
                else if (tick_1khz) begin
                    m_diff_ticks[k]++;
                    if (m_diff_ticks[k] >= DB) begin
                        m_diff_ticks[k] = 0;
                        m_lvl[k] = m_s2[k];
                        m_ev[k] = (m_lvl[k] == 0);
                    end
                end
                m_s2[k] = m_s1[k];
                m_s1[k] = raw[k];
            end
            e_en  = (tick_1khz && (m_mode == M_RUN || m_mode == M_LAP)) ? 1 : 0;
            e_clr = 0;
            if (timer_wrap && (m_mode == M_RUN || m_mode == M_LAP)) begin
                m_mode = M_PAUSE;
                m_ovf  = 1;
            end else begin
                for (int ev = 0; ev < 3; ev++) begin
                    if (m_ev[(ev == 0) ? 2 : (ev == 1) ? 0 : 1]) begin
                        nm = next_mode(m_mode, ev);
                        if (nm >= 0) begin
                            if (ev == 0) begin e_clr = 1; m_ovf = 0; m_laps = 0; end
`ifdef LAP_COUNTER_EN
                            if (m_mode == M_RUN && nm == M_LAP && m_laps < (1 << LAP_W) - 1) m_laps++;
`endif
                            m_mode = nm;
                            break;
                        end
                    end
                end
            end
            e_hold = (m_mode == M_LAP) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("state", int'(state), m_mode);
            check("count_en", int'(count_en), e_en);
            check("count_clr", int'(count_clr), e_clr);
            check("display_hold", int'(display_hold), e_hold);
            check("overflow", int'(overflow), m_ovf);
            check("lap_count", int'(lap_count), m_laps);
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mask bit0 start, bit1 lap, bit2 clear; counts outputs seen while pressed and after release.
    task automatic press(input int mask, output int n_en, output int n_clr, output int n_run);
        n_en = 0; n_clr = 0; n_run = 0;
        key_start_n = ~mask[0]; key_lap_n = ~mask[1]; key_clear_n = ~mask[2];
        for (int ph = 0; ph < 2; ph++) begin
            repeat (40) begin
                @(negedge clk);
                if (count_en)         n_en++;
                if (count_clr)        n_clr++;
                if (state == 2'b01)   n_run++;
            end
            @(posedge clk);
            #1;
            key_start_n = 1'b1; key_lap_n = 1'b1; key_clear_n = 1'b1;
        end
    endtask

    task automatic count_en_window(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (count_en) cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a, b, c, cnt;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(2);
        check("reset_state", int'(state), 0);
        check("reset_outputs", int'({count_en, count_clr, display_hold, overflow}), 0);

        // Bouncing start key never settles for two ticks: no event.
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 5 == 0) key_start_n = ~key_start_n;
            @(negedge clk);
            if (count_en) cnt++;
            @(posedge clk);
            #1;
        end
        key_start_n = 1'b1;
        wait_clk(40);
        check("bounce_state", int'(state), 0);
        check("bounce_count_en", cnt, 0);

        press(1, a, b, c);
        check("start_to_run", int'(state), 1);
        count_en_window(100, cnt);
        check("run_en_per_tick", cnt, 10);

        press(2, a, b, c);
        check("lap_state", int'(state), 2);
        check("lap_hold", int'(display_hold), 1);
        count_en_window(100, cnt);
        check("lap_en_per_tick", cnt, 10);
        press(2, a, b, c);
        check("lap_back_run", int'(state), 1);
        check("lap_hold_off", int'(display_hold), 0);
`ifdef LAP_COUNTER_EN
        check("lap_count_1", int'(lap_count), 1);
`else
        check("lap_count_tied", int'(lap_count), 0);
`endif

        press(4, a, b, c);
        check("run_clear_ignored", int'(state), 1);
        check("run_clear_no_clr", b, 0);
        press(1, a, b, c);
        check("run_to_pause", int'(state), 3);
        press(4, a, b, c);
        check("clear_pulse_once", b, 1);
        check("clear_to_idle", int'(state), 0);
        check("clear_lap_zero", int'(lap_count), 0);

        press(1, a, b, c);
        check("restart_run", int'(state), 1);
        timer_wrap = 1'b1;
        wait_clk(1);
        timer_wrap = 1'b0;
        wait_clk(1);
        check("wrap_pause", int'(state), 3);
        check("wrap_overflow", int'(overflow), 1);
        count_en_window(50, cnt);
        check("wrap_no_en", cnt, 0);
        press(4, a, b, c);
        check("wrap_clear_ovf", int'(overflow), 0);
        check("wrap_clear_idle", int'(state), 0);

        press(1, a, b, c);
        press(1, a, b, c);
        check("pause_again", int'(state), 3);
        press(5, a, b, c);
        check("both_idle", int'(state), 0);
        check("both_clr_once", b, 1);
        check("both_no_run", c, 0);

        press(1, a, b, c);
        press(2, a, b, c);
        check("pre_reset_lap", int'(state), 2);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_state", int'(state), 0);
        check("async_outputs", int'({count_en, count_clr, display_hold, overflow}), 0);
        check("async_lap_count", int'(lap_count), 0);
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(20);
        check("after_reset_idle", int'(state), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the millisecond timer datapath as a start/stop/lap/clear stopwatch. Takes the raw DE10-Lite KEY inputs and the 1 kHz tick from the clock divider. Drives the datapath's count enable and clear, plus a display-hold strobe that freezes the hex drivers during a lap. Also latches datapath rollover at 999.999 s.

Parameters:
DEBOUNCE_MS, 20, consecutive 1 kHz ticks a raw key level must be stable before it is accepted.
LAP_W, 4, width of the lap counter (only used when the optional feature is compiled in).

Ports:
clk  input  1  system clock, 50 MHz; all logic on posedge.
rst_n  input  1  asynchronous, active-low reset.
tick_1khz  input  1  single-clk-cycle strobe at 1 kHz, synchronous to clk.
key_start_n  input  1  raw start/stop key, active-low, asynchronous.
key_lap_n  input  1  raw lap key, active-low, asynchronous.
key_clear_n  input  1  raw clear key, active-low, asynchronous.
timer_wrap  input  1  one-cycle pulse from the datapath when the count rolls over from 999.999.
count_en  output  1  one-cycle advance strobe to the datapath.
count_clr  output  1  one-cycle synchronous clear to the datapath.
display_hold  output  1  level; 1 = display registers keep their last value.
overflow  output  1  sticky; 1 = rollover seen since the last clear.
state  output  2  current FSM state: IDLE=00, RUN=01, LAP=10, PAUSE=11.
lap_count  output  LAP_W  laps taken since the last clear (optional feature).

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE; count_en, count_clr, display_hold, overflow, lap_count = 0.
  - Synchronizers and debounced levels set to "released" (1); debounce counters = 0.
- Key path, per key:
  - 2-flop synchronizer.
  - Debounce counter advances only on tick_1khz while the synced level differs from the debounced level. It resets to 0 whenever the synced level equals the debounced level.
  - When the counter reaches DEBOUNCE_MS, the debounced level flips and the counter resets.
  - Press event = debounced 1->0 transition; one clk cycle wide. Release generates no event. A held key generates exactly one event.
- Simultaneous events in one cycle: clear > start > lap. Only the highest-priority event that is legal in the current state is acted on; the others are dropped.
- FSM transitions (unlisted event/state pairs are ignored):
  - IDLE: start -> RUN. clear -> count_clr pulse, stay IDLE.
  - RUN: start -> PAUSE. lap -> LAP. clear ignored (stopwatch must be stopped first).
  - LAP: lap -> RUN. start -> PAUSE.
  - PAUSE: start -> RUN. clear -> count_clr pulse, overflow<=0, -> IDLE.
- display_hold is registered and equals (next state == LAP). It asserts the cycle after the lap event and deasserts the cycle after leaving LAP.
- count_en is registered: count_en <= tick_1khz & (current state is RUN or LAP). The current state is sampled before any transition in that cycle. Latency from tick to count_en is 1 clk.
  - A start event coincident with a tick in IDLE produces no count_en for that tick.
  - A stop (start event in RUN) coincident with a tick still produces count_en for that tick.
- count_clr is registered; 1 cycle wide, asserted the cycle after the clear event.
- timer_wrap in RUN or LAP: overflow<=1 and -> PAUSE; display_hold released. timer_wrap in other states is ignored.
- count_en and count_clr are never high in the same cycle.

Optional Feature:
Macro LAP_COUNTER_EN.
- Defined:
  - lap_count increments on each RUN->LAP transition; it saturates at all-ones (no wrap).
  - lap_count resets to 0 on the same cycle count_clr asserts, and on rst_n.
- Undefined:
  - lap_count is tied to 0; no counter logic is synthesized.
  - The port remains present so top-level wiring is unchanged.

Test Plan:
- Bench parameters: DEBOUNCE_MS=2, tick every 10 clk.
- Reset then key_start_n low for 3 ticks -> one press event, state 00->01; count_en pulses 1 clk after each following tick; exactly 1 pulse per tick.
- key_start_n bounces 1/0 every 5 clk for 40 clk, then stays high -> no press event, state stays 00, count_en never asserts.
- RUN, press lap -> state=10, display_hold=1, count_en continues. Press lap again -> state=01, display_hold=0. With LAP_COUNTER_EN, lap_count=1.
- RUN, press clear -> ignored, state 01. Press start -> 11. Press clear -> count_clr high exactly 1 cycle, state 00, lap_count=0.
- RUN, pulse timer_wrap -> state=11, overflow=1, no count_en on later ticks. Clear -> overflow=0, state=00.
- PAUSE, start and clear pressed in the same cycle -> clear wins: count_clr pulse, state 00, no RUN entry.
- Assert rst_n=0 mid-LAP between clock edges -> all outputs 0 immediately (async), state 00.
